// File: rtl/fp_add_sequencer.sv
// Operand sequencer for the floating_adder stage: queues operand pairs, holds each one
// steady on add_a/add_b for the adder, and resolves special operands without the adder.
module fp_add_sequencer #(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_a,
  input  logic [31:0]              in_b,
  output logic [31:0]              add_a,
  output logic [31:0]              add_b,
  input  logic [31:0]              add_sum,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_sum,
  output logic                     out_special,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [AW:0]   C_FULL = (AW + 1)'(DEPTH);
  localparam logic [HW-1:0] C_HOLD = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_OUTPUT} state_t;

  logic [63:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  state_t        r_state;
  logic [HW-1:0] r_hold;
  logic [31:0]   r_add_a;
  logic [31:0]   r_add_b;
  logic [31:0]   r_out_sum;
  logic          r_out_special;
  logic          r_out_valid;

  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_pop_a;
  logic [31:0]   w_pop_b;
  logic [32:0]   w_cls;

  // Returns {bypass, result}; rule order matters (NaN before inf, inf before zero).
  function automatic logic [32:0] f_classify(input logic [31:0] a, input logic [31:0] b);
    logic [7:0] ea, eb;
    logic       a_max, b_max;
    ea    = a[30:23];
    eb    = b[30:23];
    a_max = (ea == 8'hFF);
    b_max = (eb == 8'hFF);
    if ((a_max && a[22:0] != 23'd0) || (b_max && b[22:0] != 23'd0))
      f_classify = {1'b1, 32'h7FC0_0000};
    else if (a_max && b_max && (a[31] != b[31]))
      f_classify = {1'b1, 32'h7FC0_0000};
    else if (a_max)
      f_classify = {1'b1, a};
    else if (b_max)
      f_classify = {1'b1, b};
    else if (ea == 8'd0 && eb == 8'd0)
      f_classify = {1'b1, a[31] & b[31], 31'd0};
    else if (ea == 8'd0)
      f_classify = {1'b1, b};
    else if (eb == 8'd0)
      f_classify = {1'b1, a};
    else if ((a ^ b) == 32'h8000_0000)
      f_classify = {1'b1, 32'h0000_0000};
    else
      f_classify = {1'b0, 32'h0000_0000};
  endfunction

  assign in_ready   = (r_count != C_FULL);
  assign w_push     = in_valid && in_ready;
  assign w_pop      = (r_state == S_IDLE) && (r_count != '0);
  assign w_pop_a    = r_mem[r_rd_ptr][63:32];
  assign w_pop_b    = r_mem[r_rd_ptr][31:0];
  assign w_cls      = f_classify(w_pop_a, w_pop_b);

  assign add_a       = r_add_a;
  assign add_b       = r_add_b;
  assign out_sum     = r_out_sum;
  assign out_special = r_out_special;
  assign out_valid   = r_out_valid;
  assign busy        = (r_state != S_IDLE);
  assign fifo_count  = r_count;

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= {in_a, in_b};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_hold        <= '0;
      r_add_a       <= '0;
      r_add_b       <= '0;
      r_out_sum     <= '0;
      r_out_special <= 1'b0;
      r_out_valid   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            if (w_cls[32]) begin
              r_out_sum     <= w_cls[31:0];
              r_out_special <= 1'b1;
              r_out_valid   <= 1'b1;
              r_state       <= S_OUTPUT;
            end else begin
              r_add_a <= w_pop_a;
              r_add_b <= w_pop_b;
              r_hold  <= C_HOLD;
              r_state <= S_ISSUE;
            end
          end
        end
        // Leaving on the 1->0 step makes the capture edge land HOLD_CYCLES after the pop.
        S_ISSUE: begin
          r_hold <= r_hold - 1'b1;
          if (r_hold <= 1)
            r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          r_out_sum     <= add_sum;
          r_out_special <= 1'b0;
          r_out_valid   <= 1'b1;
          r_state       <= S_OUTPUT;
        end
        S_OUTPUT: begin
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Directed bench for fp_add_sequencer with a table-driven stand-in for the adder.
`timescale 1ns/1ps

module tb_fp_add_sequencer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] add_sum;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_special;
  logic        busy;
  logic [2:0]  fifo_count;

  int tests = 0;
  int fails = 0;
  logic [32:0] got_q[$];

  fp_add_sequencer #(.DEPTH(4), .HOLD_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_special(out_special), .busy(busy), .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Hand-computed sums for every normal pair the bench issues.
  function automatic logic [31:0] fsum(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F80_0000, 32'h3F80_0000}: return 32'h4000_0000;
      {32'h3F80_0000, 32'h4000_0000}: return 32'h4040_0000;
      {32'h4000_0000, 32'h4000_0000}: return 32'h4080_0000;
      {32'h4000_0000, 32'h4080_0000}: return 32'h40C0_0000;
      {32'h4080_0000, 32'h4080_0000}: return 32'h4100_0000;
      default:                        return 32'hBADB_AD00;
    endcase
  endfunction

  always @(negedge clk) add_sum <= fsum(add_a, add_b);

  always @(posedge clk)
    if (rst_n && out_valid && out_ready) got_q.push_back({out_special, out_sum});

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b);
    int guard;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    guard    = 0;
    while (!in_ready && guard < 100) begin
      tick();
      guard++;
    end
    chk("push_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_n(input int n);
    int guard;
    guard = 0;
    while (got_q.size() < n && guard < 200) begin
      tick();
      guard++;
    end
    chk("wait_results", (got_q.size() >= n), 1'b1);
  endtask

  task automatic wait_valid();
    int guard;
    guard = 0;
    while (!out_valid && guard < 50) begin
      tick();
      guard++;
    end
    chk("wait_valid", out_valid, 1'b1);
  endtask

  initial begin
    logic [31:0] exp2 [5];
    int base;
    exp2 = '{32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40C0_0000, 32'h4100_0000};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_sum", out_sum, 32'h0);
    chk("rst_out_special", out_special, 1'b0);
    chk("rst_add_a", add_a, 32'h0);
    chk("rst_add_b", add_b, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_count", fifo_count, 3'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    tick();

    // 1 + 2: push at N, pop at N+1, capture at N+3
    push(32'h3F80_0000, 32'h4000_0000);
    chk("t1_count_push", fifo_count, 3'd1);
    chk("t1_busy_push", busy, 1'b0);
    tick();
    chk("t1_busy_pop", busy, 1'b1);
    chk("t1_add_a", add_a, 32'h3F80_0000);
    chk("t1_add_b", add_b, 32'h4000_0000);
    chk("t1_count_pop", fifo_count, 3'd0);
    tick();
    chk("t1_valid_early", out_valid, 1'b0);
    tick();
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_sum", out_sum, 32'h4040_0000);
    chk("t1_special", out_special, 1'b0);
    tick();
    chk("t1_valid_drop", out_valid, 1'b0);
    chk("t1_idle", busy, 1'b0);

    // five pairs back to back into a four-deep FIFO
    base = got_q.size();
    push(32'h3F80_0000, 32'h3F80_0000);
    push(32'h3F80_0000, 32'h4000_0000);
    push(32'h4000_0000, 32'h4000_0000);
    push(32'h4000_0000, 32'h4080_0000);
    push(32'h4080_0000, 32'h4080_0000);
    chk("t2_full_count", fifo_count, 3'd4);
    chk("t2_full_ready", in_ready, 1'b0);
    wait_n(base + 5);
    for (int i = 0; i < 5; i++)
      chk("t2_result", got_q[base + i], {1'b0, exp2[i]});

    // +inf + -inf
    base = got_q.size();
    push(32'h7F80_0000, 32'hFF80_0000);
    wait_n(base + 1);
    chk("t3_result", got_q[base], {1'b1, 32'h7FC0_0000});
    chk("t3_add_a_held", add_a, 32'h4080_0000);
    chk("t3_add_b_held", add_b, 32'h4080_0000);

    // zero operand and exact cancel
    base = got_q.size();
    push(32'h0000_0000, 32'hC1C8_0000);
    push(32'h41C8_0000, 32'hC1C8_0000);
    wait_n(base + 2);
    chk("t4_zero", got_q[base], {1'b1, 32'hC1C8_0000});
    chk("t4_cancel", got_q[base + 1], {1'b1, 32'h0000_0000});
    chk("t4_add_a_held", add_a, 32'h4080_0000);

    // backpressure with a second pair queued
    out_ready = 1'b0;
    base = got_q.size();
    push(32'h3F80_0000, 32'h4000_0000);
    push(32'h4000_0000, 32'h4000_0000);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      chk("t5_hold_sum", out_sum, 32'h4040_0000);
      chk("t5_hold_valid", out_valid, 1'b1);
      chk("t5_hold_count", fifo_count, 3'd1);
      tick();
    end
    out_ready = 1'b1;
    wait_n(base + 2);
    chk("t5_first", got_q[base], {1'b0, 32'h4040_0000});
    chk("t5_second", got_q[base + 1], {1'b0, 32'h4080_0000});

    // reset while ISSUE is active with two pairs still queued
    out_ready = 1'b0;
    base = got_q.size();
    push(32'h3F80_0000, 32'h3F80_0000);
    push(32'h4000_0000, 32'h4000_0000);
    push(32'h3F80_0000, 32'h4000_0000);
    push(32'h4000_0000, 32'h4080_0000);
    wait_valid();
    chk("t6_queued", fifo_count, 3'd3);
    out_ready = 1'b1;
    tick();
    chk("t6_idle", busy, 1'b0);
    tick();
    chk("t6_issue_busy", busy, 1'b1);
    chk("t6_issue_count", fifo_count, 3'd2);
    chk("t6_issue_add_a", add_a, 32'h4000_0000);
    rst_n = 1'b0;
    tick();
    chk("t6_rst_count", fifo_count, 3'd0);
    chk("t6_rst_valid", out_valid, 1'b0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_add_a", add_a, 32'h0);
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    chk("t6_after_count", fifo_count, 3'd0);
    chk("t6_after_busy", busy, 1'b0);
    chk("t6_after_valid", out_valid, 1'b0);
    chk("t6_results", (got_q.size() == base + 1), 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
